// File: rtl/addr_region_decoder_pkg.sv
// rtl/addr_region_decoder_pkg.sv - shared types and constants for the address region decoder
package addr_region_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        ACK  = 3'd2,
        MISS = 3'd3,
        BERR = 3'd4
    } decoder_state_t;

    localparam int CFG_MATCH_W = 8;
    localparam int CFG_WAIT_W  = 3;

    typedef struct packed {
        logic [CFG_MATCH_W-1:0] match;
        logic [CFG_MATCH_W-1:0] mask;
        logic [CFG_WAIT_W-1:0]  wait_states;
    } region_cfg_t;

    // Top levels index cs_n by these names rather than raw numbers.
    localparam int REGION_ROM       = 0;
    localparam int REGION_WORK      = 1;
    localparam int REGION_SCREEN0   = 2;
    localparam int REGION_SCREEN1   = 3;
    localparam int REGION_PALETTE   = 4;
    localparam int REGION_IO        = 5;
    localparam int REGION_SOUND     = 6;
    localparam int REGION_SAVESTATE = 7;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addr_region_match.sv
// rtl/addr_region_match.sv - combinational mask/match compare with lowest-index priority
module addr_region_match
    import addr_region_decoder_pkg::*;
#(
    parameter int                     NUM_REGIONS = 16,
    parameter int                     ADDR_W      = 24,
    parameter int                     MATCH_W     = 8,
    parameter logic [NUM_REGIONS-1:0] SS_ONLY     = '0
) (
    input  logic [ADDR_W-1:0]                 addr_i,
    input  logic                              ss_override_i,
    input  logic [NUM_REGIONS*MATCH_W-1:0]    cfg_match_i,
    input  logic [NUM_REGIONS*MATCH_W-1:0]    cfg_mask_i,
    input  logic [NUM_REGIONS-1:0]            cfg_enable_i,
    output logic                              hit_o,
    output logic [idx_width(NUM_REGIONS)-1:0] win_o,
    output logic [NUM_REGIONS-1:0]            onehot_o
);

    localparam int IDX_W = idx_width(NUM_REGIONS);

    logic [MATCH_W-1:0]     addr_hi;
    logic [NUM_REGIONS-1:0] hits;

    assign addr_hi = addr_i[ADDR_W-1 -: MATCH_W];

    generate
        if (ADDR_W > MATCH_W) begin : g_low_bits
            logic unused_low_addr;
            assign unused_low_addr = ^addr_i[ADDR_W-MATCH_W-1:0];
        end
    endgenerate

    always_comb begin
        hits = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            hits[i] = cfg_enable_i[i]
                    & ((addr_hi & cfg_mask_i[i*MATCH_W +: MATCH_W]) == cfg_match_i[i*MATCH_W +: MATCH_W])
                    & (~SS_ONLY[i] | ss_override_i);
        end
    end

    // Isolating the lowest set bit gives the priority winner as a one-hot vector.
    assign onehot_o = hits & (~hits + NUM_REGIONS'(1));
    assign hit_o    = |hits;

    always_comb begin
        win_o = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hits[i]) begin
                win_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/addr_region_decoder.sv
// rtl/addr_region_decoder.sv - registered chip-select decoder with wait states, DTACK and bus error
module addr_region_decoder
    import addr_region_decoder_pkg::*;
#(
    parameter int                     NUM_REGIONS = 16,
    parameter int                     ADDR_W      = 24,
    parameter int                     MATCH_W     = 8,
    parameter int                     WAIT_W      = 3,
    parameter int                     BERR_CYCLES = 64,
    parameter logic [NUM_REGIONS-1:0] SS_ONLY     = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cpu_as_n,
    input  logic [1:0]                        cpu_ds_n,
    input  logic [ADDR_W-1:0]                 cpu_word_addr,
    input  logic                              ss_override,
    input  logic [NUM_REGIONS*MATCH_W-1:0]    cfg_match,
    input  logic [NUM_REGIONS*MATCH_W-1:0]    cfg_mask,
    input  logic [NUM_REGIONS*WAIT_W-1:0]     cfg_wait,
    input  logic [NUM_REGIONS-1:0]            cfg_enable,
    input  logic [NUM_REGIONS-1:0]            ext_ready,
    output logic [NUM_REGIONS-1:0]            cs_n,
    output logic [idx_width(NUM_REGIONS)-1:0] region_idx,
    output logic                              dtack_n,
    output logic                              berr_n
);

    localparam int IDX_W  = idx_width(NUM_REGIONS);
    localparam int BERR_W = idx_width(BERR_CYCLES);
    localparam int CNT_W  = (WAIT_W > BERR_W) ? WAIT_W : BERR_W;

    decoder_state_t         state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   armed_q;
    logic [IDX_W-1:0]       win_q;
    logic [NUM_REGIONS-1:0] onehot_q;
    logic [NUM_REGIONS-1:0] cs_n_q;
    logic [IDX_W-1:0]       region_idx_q;
    logic                   dtack_n_q;
    logic                   berr_n_q;

    logic                   m_hit;
    logic [IDX_W-1:0]       m_win;
    logic [NUM_REGIONS-1:0] m_onehot;
    logic [WAIT_W-1:0]      sel_wait;
    logic                   strobe;

    addr_region_match #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .MATCH_W     (MATCH_W),
        .SS_ONLY     (SS_ONLY)
    ) u_match (
        .addr_i        (cpu_word_addr),
        .ss_override_i (ss_override),
        .cfg_match_i   (cfg_match),
        .cfg_mask_i    (cfg_mask),
        .cfg_enable_i  (cfg_enable),
        .hit_o         (m_hit),
        .win_o         (m_win),
        .onehot_o      (m_onehot)
    );

    assign sel_wait = cfg_wait[int'(m_win)*WAIT_W +: WAIT_W];
    assign strobe   = ~cpu_as_n & ~&cpu_ds_n;

    // armed_q marks the first cycle after decode: chip select is driven there,
    // and counting starts only on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            win_q        <= '0;
            onehot_q     <= '0;
            cs_n_q       <= '1;
            region_idx_q <= '0;
            dtack_n_q    <= 1'b1;
            berr_n_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cs_n_q    <= '1;
                    dtack_n_q <= 1'b1;
                    berr_n_q  <= 1'b1;
                    armed_q   <= 1'b0;
                    if (strobe) begin
                        win_q    <= m_win;
                        onehot_q <= m_onehot;
                        if (m_hit) begin
                            cnt_q   <= CNT_W'(sel_wait);
                            state_q <= WAIT;
                        end else begin
                            cnt_q   <= CNT_W'(BERR_CYCLES - 1);
                            state_q <= MISS;
                        end
                    end
                end
                WAIT: begin
                    if (cpu_as_n) begin
                        state_q <= IDLE;
                        cs_n_q  <= '1;
                    end else if (!armed_q) begin
                        armed_q      <= 1'b1;
                        cs_n_q       <= ~onehot_q;
                        region_idx_q <= win_q;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (ext_ready[win_q]) begin
                        state_q   <= ACK;
                        dtack_n_q <= 1'b0;
                    end
                end
                ACK: begin
                    if (cpu_as_n) begin
                        state_q <= IDLE;
                    end
                end
                MISS: begin
                    if (cpu_as_n) begin
                        state_q <= IDLE;
                    end else if (!armed_q) begin
                        armed_q <= 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q  <= BERR;
                        berr_n_q <= 1'b0;
                    end
                end
                BERR: begin
                    if (cpu_as_n) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cs_n       = cs_n_q;
    assign region_idx = region_idx_q;
    assign dtack_n    = dtack_n_q;
    assign berr_n     = berr_n_q;

endmodule

// File: tb/tb_addr_region_decoder.sv
// tb/tb_addr_region_decoder.sv - directed self-checking bench for addr_region_decoder
module tb_addr_region_decoder;
    import addr_region_decoder_pkg::*;

    localparam int N  = 16;
    localparam int AW = 24;
    localparam int MW = 8;
    localparam int WW = 3;
    localparam int BC = 64;
    localparam logic [N-1:0] SS = 16'h0080;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_as_n;
    logic [1:0]    cpu_ds_n;
    logic [AW-1:0] cpu_word_addr;
    logic          ss_override;
    logic [N*MW-1:0] cfg_match;
    logic [N*MW-1:0] cfg_mask;
    logic [N*WW-1:0] cfg_wait;
    logic [N-1:0]  cfg_enable;
    logic [N-1:0]  ext_ready;
    logic [N-1:0]  cs_n;
    logic [3:0]    region_idx;
    logic          dtack_n;
    logic          berr_n;

    int n_checks = 0;
    int n_errors = 0;

    addr_region_decoder #(
        .NUM_REGIONS (N),
        .ADDR_W      (AW),
        .MATCH_W     (MW),
        .WAIT_W      (WW),
        .BERR_CYCLES (BC),
        .SS_ONLY     (SS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_as_n      (cpu_as_n),
        .cpu_ds_n      (cpu_ds_n),
        .cpu_word_addr (cpu_word_addr),
        .ss_override   (ss_override),
        .cfg_match     (cfg_match),
        .cfg_mask      (cfg_mask),
        .cfg_wait      (cfg_wait),
        .cfg_enable    (cfg_enable),
        .ext_ready     (ext_ready),
        .cs_n          (cs_n),
        .region_idx    (region_idx),
        .dtack_n       (dtack_n),
        .berr_n        (berr_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic set_region(input int i, input region_cfg_t c, input logic en);
        cfg_match[i*MW +: MW] = c.match;
        cfg_mask[i*MW +: MW]  = c.mask;
        cfg_wait[i*WW +: WW]  = c.wait_states;
        cfg_enable[i]         = en;
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic [1:0] ds);
        cpu_word_addr = a;
        cpu_ds_n      = ds;
        cpu_as_n      = 1'b0;
    endtask

    task automatic release_bus();
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        step(2);
    endtask

    initial begin
        logic seen;
        reset         = 1'b1;
        cpu_as_n      = 1'b1;
        cpu_ds_n      = 2'b11;
        cpu_word_addr = '0;
        ss_override   = 1'b0;
        cfg_match     = '0;
        cfg_mask      = '0;
        cfg_wait      = '0;
        cfg_enable    = '0;
        ext_ready     = '1;
        @(negedge clk);
        step(2);
        check("rst_cs_n", 32'(cs_n), 32'hffff);
        check("rst_idx", 32'(region_idx), 32'h0);
        check("rst_dtack", 32'(dtack_n), 32'h1);
        check("rst_berr", 32'(berr_n), 32'h1);
        reset = 1'b0;

        set_region(REGION_SCREEN0,   '{match: 8'h10, mask: 8'hff, wait_states: 3'd0}, 1'b1);
        set_region(REGION_WORK,      '{match: 8'h20, mask: 8'hff, wait_states: 3'd0}, 1'b1);
        set_region(REGION_IO,        '{match: 8'h20, mask: 8'hf0, wait_states: 3'd0}, 1'b1);
        set_region(REGION_SCREEN1,   '{match: 8'h30, mask: 8'hff, wait_states: 3'd3}, 1'b1);
        set_region(REGION_SAVESTATE, '{match: 8'hff, mask: 8'hff, wait_states: 3'd1}, 1'b1);
        step(1);

        // region 2, zero wait states
        drive(24'h100000, 2'b00);
        step(1);
        check("r2_cs_at_N", 32'(cs_n), 32'hffff);
        step(1);
        check("r2_cs_at_N1", 32'(cs_n), 32'hfffb);
        check("r2_idx", 32'(region_idx), 32'd2);
        check("r2_dtack_at_N1", 32'(dtack_n), 32'h1);
        step(1);
        check("r2_dtack_at_N2", 32'(dtack_n), 32'h0);
        release_bus();
        check("r2_rel_cs", 32'(cs_n), 32'hffff);
        check("r2_rel_dtack", 32'(dtack_n), 32'h1);

        // overlap: regions 1 and 5, lowest wins
        drive(24'h201234, 2'b01);
        step(2);
        check("ovl_cs", 32'(cs_n), 32'hfffd);
        check("ovl_idx", 32'(region_idx), 32'd1);
        step(1);
        check("ovl_dtack", 32'(dtack_n), 32'h0);
        release_bus();
        cfg_enable[REGION_WORK] = 1'b0;
        drive(24'h201234, 2'b10);
        step(2);
        check("ovl_dis_cs", 32'(cs_n), 32'hffdf);
        check("ovl_dis_idx", 32'(region_idx), 32'd5);
        release_bus();

        // wait=3 with ext_ready low four extra cycles
        ext_ready[3] = 1'b0;
        drive(24'h300000, 2'b00);
        step(1);
        step(8);
        check("w3_dtack_N8", 32'(dtack_n), 32'h1);
        check("w3_cs_N8", 32'(cs_n), 32'hfff7);
        ext_ready[3] = 1'b1;
        step(1);
        check("w3_dtack_N9", 32'(dtack_n), 32'h0);
        release_bus();

        // abort in WAIT
        drive(24'h300000, 2'b00);
        step(2);
        check("abort_cs_N1", 32'(cs_n), 32'hfff7);
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        step(1);
        check("abort_cs_rel", 32'(cs_n), 32'hffff);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (dtack_n == 1'b0) seen = 1'b1;
            step(1);
        end
        check("abort_no_dtack", 32'(seen), 32'h0);

        // unmapped access
        drive(24'hee0000, 2'b00);
        step(1);
        seen = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            step(1);
            if (cs_n != 16'hffff) seen = 1'b1;
        end
        check("miss_berr_N64", 32'(berr_n), 32'h1);
        step(1);
        check("miss_berr_N65", 32'(berr_n), 32'h0);
        check("miss_dtack", 32'(dtack_n), 32'h1);
        check("miss_cs_never", 32'(seen | (cs_n != 16'hffff)), 32'h0);
        release_bus();
        check("miss_rel_berr", 32'(berr_n), 32'h1);

        // save-state only region
        ss_override = 1'b0;
        drive(24'hff1234, 2'b00);
        step(66);
        check("ss_off_berr", 32'(berr_n), 32'h0);
        check("ss_off_cs", 32'(cs_n), 32'hffff);
        release_bus();
        ss_override = 1'b1;
        drive(24'hff1234, 2'b00);
        step(2);
        check("ss_on_cs", 32'(cs_n), 32'hff7f);
        check("ss_on_idx", 32'(region_idx), 32'd7);
        step(2);
        check("ss_on_dtack", 32'(dtack_n), 32'h0);
        release_bus();
        ss_override = 1'b0;

        // reset during WAIT
        drive(24'h300000, 2'b00);
        step(3);
        check("rw_cs_pre", 32'(cs_n), 32'hfff7);
        reset    = 1'b1;
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        step(1);
        check("rw_cs", 32'(cs_n), 32'hffff);
        check("rw_idx", 32'(region_idx), 32'h0);
        check("rw_dtack", 32'(dtack_n), 32'h1);
        check("rw_berr", 32'(berr_n), 32'h1);
        reset = 1'b0;
        step(1);

        // normal access after reset, then reset during ACK
        drive(24'h100000, 2'b00);
        step(2);
        check("post_rst_cs", 32'(cs_n), 32'hfffb);
        step(1);
        check("ra_dtack_pre", 32'(dtack_n), 32'h0);
        reset    = 1'b1;
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        step(1);
        check("ra_dtack", 32'(dtack_n), 32'h1);
        check("ra_cs", 32'(cs_n), 32'hffff);
        check("ra_idx", 32'(region_idx), 32'h0);
        reset = 1'b0;
        step(1);
        drive(24'h2a0000, 2'b00);
        step(2);
        check("ra_next_cs", 32'(cs_n), 32'hffdf);
        step(1);
        check("ra_next_dtack", 32'(dtack_n), 32'h0);
        release_bus();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
